// File: rtl/bsg_manycore_link_sif_edge_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_manycore_link_sif_edge_buffer_if                                        |
// | Flattened inner/outer link_sif bundle for the array edge buffer.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface bsg_manycore_link_sif_edge_buffer_if #(
  parameter int addr_width_p   = 16,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 3
) ();
  // link_sif layout, MSB first: fwd{v, data, ready_and_rev}, rev{v, data, ready_and_rev}
  localparam int fwd_data_width_lp = addr_width_p + data_width_p
                                   + 2 * (x_cord_width_p + y_cord_width_p);
  localparam int rev_data_width_lp = data_width_p + x_cord_width_p + y_cord_width_p;
  localparam int link_sif_width_lp = fwd_data_width_lp + rev_data_width_lp + 4;

  logic [link_sif_width_lp-1:0] inner_link_sif_i;
  logic [link_sif_width_lp-1:0] inner_link_sif_o;
  logic [link_sif_width_lp-1:0] outer_link_sif_i;
  logic [link_sif_width_lp-1:0] outer_link_sif_o;

  modport slave (
    input  inner_link_sif_i,
    input  outer_link_sif_i,
    output inner_link_sif_o,
    output outer_link_sif_o
  );

  modport master (
    output inner_link_sif_i,
    output outer_link_sif_i,
    input  inner_link_sif_o,
    input  outer_link_sif_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_manycore_link_sif_edge_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_manycore_link_sif_edge_buffer                                           |
// | Four 2-entry valid/ready FIFOs fully retiming one manycore edge link_sif.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bsg_manycore_link_sif_edge_buffer_fifo #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);
  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_one   = 2'd1;
  localparam logic [1:0] c_full  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic               r_ready;
  logic               r_rptr;
  logic               r_wptr;
  logic [width_p-1:0] r_mem [2];
  logic               w_enq;
  logic               w_deq;

  assign w_enq = v_i & r_ready;
  assign w_deq = v_o & ready_i;

  // Ready is registered from the next state so downstream ready never reaches upstream combinationally
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= c_empty;
      r_ready <= 1'b0;
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next != c_full);
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_empty: if (w_enq) w_state_next = c_one;
      c_one: begin
        if (w_enq && !w_deq)      w_state_next = c_full;
        else if (!w_enq && w_deq) w_state_next = c_empty;
      end
      c_full:  if (w_deq) w_state_next = c_one;
      default: w_state_next = c_empty;
    endcase
  end

  always_comb begin
    v_o     = (r_state != c_empty);
    ready_o = r_ready;
    data_o  = r_mem[r_rptr];
  end
endmodule

module bsg_manycore_link_sif_edge_buffer #(
  parameter int addr_width_p   = 16,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 3
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_manycore_link_sif_edge_buffer_if.slave link_sif,
  output logic idle_o
);
  localparam int fwd_w_lp = addr_width_p + data_width_p + 2 * (x_cord_width_p + y_cord_width_p);
  localparam int rev_w_lp = data_width_p + x_cord_width_p + y_cord_width_p;
  localparam int link_sif_width_lp = fwd_w_lp + rev_w_lp + 4;

  localparam int rev_ready_lp = 0;
  localparam int rev_data_lp  = 1;
  localparam int rev_v_lp     = rev_w_lp + 1;
  localparam int fwd_ready_lp = rev_w_lp + 2;
  localparam int fwd_data_lp  = rev_w_lp + 3;
  localparam int fwd_v_lp     = link_sif_width_lp - 1;

  logic w_f_out_v;
  logic w_f_in_v;
  logic w_r_out_v;
  logic w_r_in_v;

  bsg_manycore_link_sif_edge_buffer_fifo #(.width_p(fwd_w_lp)) f_out (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (link_sif.inner_link_sif_i[fwd_v_lp]),
    .data_i    (link_sif.inner_link_sif_i[fwd_data_lp +: fwd_w_lp]),
    .ready_o   (link_sif.inner_link_sif_o[fwd_ready_lp]),
    .v_o       (w_f_out_v),
    .data_o    (link_sif.outer_link_sif_o[fwd_data_lp +: fwd_w_lp]),
    .ready_i   (link_sif.outer_link_sif_i[fwd_ready_lp])
  );

  bsg_manycore_link_sif_edge_buffer_fifo #(.width_p(fwd_w_lp)) f_in (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (link_sif.outer_link_sif_i[fwd_v_lp]),
    .data_i    (link_sif.outer_link_sif_i[fwd_data_lp +: fwd_w_lp]),
    .ready_o   (link_sif.outer_link_sif_o[fwd_ready_lp]),
    .v_o       (w_f_in_v),
    .data_o    (link_sif.inner_link_sif_o[fwd_data_lp +: fwd_w_lp]),
    .ready_i   (link_sif.inner_link_sif_i[fwd_ready_lp])
  );

  bsg_manycore_link_sif_edge_buffer_fifo #(.width_p(rev_w_lp)) r_out (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (link_sif.inner_link_sif_i[rev_v_lp]),
    .data_i    (link_sif.inner_link_sif_i[rev_data_lp +: rev_w_lp]),
    .ready_o   (link_sif.inner_link_sif_o[rev_ready_lp]),
    .v_o       (w_r_out_v),
    .data_o    (link_sif.outer_link_sif_o[rev_data_lp +: rev_w_lp]),
    .ready_i   (link_sif.outer_link_sif_i[rev_ready_lp])
  );

  bsg_manycore_link_sif_edge_buffer_fifo #(.width_p(rev_w_lp)) r_in (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (link_sif.outer_link_sif_i[rev_v_lp]),
    .data_i    (link_sif.outer_link_sif_i[rev_data_lp +: rev_w_lp]),
    .ready_o   (link_sif.outer_link_sif_o[rev_ready_lp]),
    .v_o       (w_r_in_v),
    .data_o    (link_sif.inner_link_sif_o[rev_data_lp +: rev_w_lp]),
    .ready_i   (link_sif.inner_link_sif_i[rev_ready_lp])
  );

  assign link_sif.outer_link_sif_o[fwd_v_lp] = w_f_out_v;
  assign link_sif.inner_link_sif_o[fwd_v_lp] = w_f_in_v;
  assign link_sif.outer_link_sif_o[rev_v_lp] = w_r_out_v;
  assign link_sif.inner_link_sif_o[rev_v_lp] = w_r_in_v;

  assign idle_o = ~(w_f_out_v | w_f_in_v | w_r_out_v | w_r_in_v);
endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_link_sif_edge_buffer.sv
`default_nettype none
// Directed self-checking bench for bsg_manycore_link_sif_edge_buffer.
module tb_bsg_manycore_link_sif_edge_buffer;
  localparam int FW = 16 + 32 + 2 * (4 + 3);
  localparam int RW = 32 + 4 + 3;
  localparam int LW = FW + RW + 4;
  localparam int FD = RW + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic          in_fwd_v = 1'b0, in_fwd_rdy = 1'b1, in_rev_v = 1'b0, in_rev_rdy = 1'b1;
  logic [FW-1:0] in_fwd_data = '0;
  logic [RW-1:0] in_rev_data = '0;
  logic          out_fwd_v = 1'b0, out_fwd_rdy = 1'b1, out_rev_v = 1'b0, out_rev_rdy = 1'b1;
  logic [FW-1:0] out_fwd_data = '0;
  logic [RW-1:0] out_rev_data = '0;
  logic          idle;

  bsg_manycore_link_sif_edge_buffer_if #(
    .addr_width_p(16), .data_width_p(32), .x_cord_width_p(4), .y_cord_width_p(3)
  ) link_sif ();

  assign link_sif.inner_link_sif_i = {in_fwd_v, in_fwd_data, in_fwd_rdy, in_rev_v, in_rev_data, in_rev_rdy};
  assign link_sif.outer_link_sif_i = {out_fwd_v, out_fwd_data, out_fwd_rdy, out_rev_v, out_rev_data, out_rev_rdy};

  wire          ino_fwd_v     = link_sif.inner_link_sif_o[LW-1];
  wire [FW-1:0] ino_fwd_data  = link_sif.inner_link_sif_o[FD +: FW];
  wire          ino_fwd_rdy   = link_sif.inner_link_sif_o[RW+2];
  wire          ino_rev_v     = link_sif.inner_link_sif_o[RW+1];
  wire [RW-1:0] ino_rev_data  = link_sif.inner_link_sif_o[1 +: RW];
  wire          ino_rev_rdy   = link_sif.inner_link_sif_o[0];
  wire          outo_fwd_v    = link_sif.outer_link_sif_o[LW-1];
  wire [FW-1:0] outo_fwd_data = link_sif.outer_link_sif_o[FD +: FW];
  wire          outo_fwd_rdy  = link_sif.outer_link_sif_o[RW+2];
  wire          outo_rev_v    = link_sif.outer_link_sif_o[RW+1];
  wire [RW-1:0] outo_rev_data = link_sif.outer_link_sif_o[1 +: RW];
  wire          outo_rev_rdy  = link_sif.outer_link_sif_o[0];

  bsg_manycore_link_sif_edge_buffer #(
    .addr_width_p(16), .data_width_p(32), .x_cord_width_p(4), .y_cord_width_p(3)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .link_sif  (link_sif),
    .idle_o    (idle)
  );

  // Reset-time view: all v low, all ready low, idle high.
  task automatic check_reset_outputs(input string tag);
    logic [3:0] v, r;
    v = {outo_fwd_v, ino_fwd_v, outo_rev_v, ino_rev_v};
    r = {ino_fwd_rdy, outo_fwd_rdy, ino_rev_rdy, outo_rev_rdy};
    tests++; if (v !== 4'b0000) begin fails++; $display("FAIL %s_v: got %b, expected 0000", tag, v); end
    tests++; if (r !== 4'b0000) begin fails++; $display("FAIL %s_ready: got %b, expected 0000", tag, r); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL %s_idle: got %b, expected 1", tag, idle); end
  endtask

  task automatic test_reset();
    logic [3:0] r;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    r = {ino_fwd_rdy, outo_fwd_rdy, ino_rev_rdy, outo_rev_rdy};
    tests++; if (r !== 4'b0000) begin fails++; $display("FAIL reset_release_ready: got %b, expected 0000", r); end
    @(negedge clk);
    r = {ino_fwd_rdy, outo_fwd_rdy, ino_rev_rdy, outo_rev_rdy};
    tests++; if (r !== 4'b1111) begin fails++; $display("FAIL reset_first_edge_ready: got %b, expected 1111", r); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_first_edge_idle: got %b, expected 1", idle); end
  endtask

  task automatic test_single_packet();
    tests++; if (outo_fwd_v !== 1'b0) begin fails++; $display("FAIL single_pre_v: got %b, expected 0", outo_fwd_v); end
    in_fwd_v = 1'b1; in_fwd_data = FW'(32'h1234_5678); out_fwd_rdy = 1'b1;
    @(negedge clk);
    in_fwd_v = 1'b0;
    tests++; if (outo_fwd_v !== 1'b1 || outo_fwd_data !== FW'(32'h1234_5678))
      begin fails++; $display("FAIL single_out: got v=%b data=%h, expected v=1 data=%h", outo_fwd_v, outo_fwd_data, FW'(32'h1234_5678)); end
    tests++; if (idle !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b, expected 0", idle); end
    @(negedge clk);
    tests++; if (outo_fwd_v !== 1'b0) begin fails++; $display("FAIL single_post_v: got %b, expected 0", outo_fwd_v); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL single_idle_after: got %b, expected 1", idle); end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] got[$];
    int idx = 0;
    in_rev_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin
        tests++; if (outo_rev_rdy !== 1'b0) begin fails++; $display("FAIL bp_ready_drop: got %b, expected 0", outo_rev_rdy); end
      end
      if (idx < 4) begin
        out_rev_v = 1'b1; out_rev_data = RW'(idx + 1);
        if (outo_rev_rdy) idx++;
      end
      @(negedge clk);
    end
    tests++; if (idx !== 2) begin fails++; $display("FAIL bp_accepted: got %0d, expected 2", idx); end
    tests++; if (ino_rev_v !== 1'b1 || ino_rev_data !== RW'(1))
      begin fails++; $display("FAIL bp_head: got v=%b data=%h, expected v=1 data=1", ino_rev_v, ino_rev_data); end
    in_rev_rdy = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      if (c == 1) begin
        tests++; if (outo_rev_rdy !== 1'b1) begin fails++; $display("FAIL bp_ready_recover: got %b, expected 1", outo_rev_rdy); end
      end
      if (ino_rev_v) got.push_back(ino_rev_data);
      if (idx < 4) begin
        out_rev_v = 1'b1; out_rev_data = RW'(idx + 1);
        if (outo_rev_rdy) idx++;
      end else out_rev_v = 1'b0;
      @(negedge clk);
    end
    out_rev_v = 1'b0;
    tests++; if (got.size() !== 4) begin fails++; $display("FAIL bp_count: got %0d, expected 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      tests++; if (got[i] !== RW'(i + 1)) begin fails++; $display("FAIL bp_order[%0d]: got %h, expected %h", i, got[i], RW'(i + 1)); end
    end
    @(negedge clk);
    tests++; if (ino_rev_v !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got v=%b, expected 0", ino_rev_v); end
  endtask

  task automatic test_throughput();
    logic [3:0] r;
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        tests++; if (outo_fwd_v !== 1'b1 || outo_fwd_data !== FW'(32'h1000 + i - 1))
          begin fails++; $display("FAIL tp_f_out[%0d]: got v=%b data=%h, expected v=1 data=%h", i-1, outo_fwd_v, outo_fwd_data, FW'(32'h1000 + i - 1)); end
        tests++; if (ino_fwd_v !== 1'b1 || ino_fwd_data !== FW'(32'h2000 + i - 1))
          begin fails++; $display("FAIL tp_f_in[%0d]: got v=%b data=%h, expected v=1 data=%h", i-1, ino_fwd_v, ino_fwd_data, FW'(32'h2000 + i - 1)); end
        tests++; if (outo_rev_v !== 1'b1 || outo_rev_data !== RW'(32'h3000 + i - 1))
          begin fails++; $display("FAIL tp_r_out[%0d]: got v=%b data=%h, expected v=1 data=%h", i-1, outo_rev_v, outo_rev_data, RW'(32'h3000 + i - 1)); end
        tests++; if (ino_rev_v !== 1'b1 || ino_rev_data !== RW'(32'h4000 + i - 1))
          begin fails++; $display("FAIL tp_r_in[%0d]: got v=%b data=%h, expected v=1 data=%h", i-1, ino_rev_v, ino_rev_data, RW'(32'h4000 + i - 1)); end
      end
      r = {ino_fwd_rdy, outo_fwd_rdy, ino_rev_rdy, outo_rev_rdy};
      tests++; if (r !== 4'b1111) begin fails++; $display("FAIL tp_ready[%0d]: got %b, expected 1111", i, r); end
      in_fwd_v  = (i < 100); in_fwd_data  = FW'(32'h1000 + i);
      out_fwd_v = (i < 100); out_fwd_data = FW'(32'h2000 + i);
      in_rev_v  = (i < 100); in_rev_data  = RW'(32'h3000 + i);
      out_rev_v = (i < 100); out_rev_data = RW'(32'h4000 + i);
      @(negedge clk);
    end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL tp_idle: got %b, expected 1", idle); end
  endtask

  task automatic test_random_ready();
    logic [FW-1:0] q[$];
    logic [FW-1:0] nxt;
    int occ, delivered;
    bit rdy;
    nxt = FW'(32'h5000);
    delivered = 0;
    for (int c = 0; c < 200; c++) begin
      occ = q.size();
      tests++; if (outo_fwd_v !== (occ > 0) || ino_fwd_rdy !== (occ < 2))
        begin fails++; $display("FAIL rnd_state[%0d]: got v=%b ready=%b, expected v=%b ready=%b", c, outo_fwd_v, ino_fwd_rdy, occ > 0, occ < 2); end
      if (occ > 0) begin
        tests++; if (outo_fwd_data !== q[0])
          begin fails++; $display("FAIL rnd_data[%0d]: got %h, expected %h", c, outo_fwd_data, q[0]); end
      end
      rdy = 1'($urandom_range(0, 1));
      out_fwd_rdy = rdy; in_fwd_v = 1'b1; in_fwd_data = nxt;
      if (occ > 0 && rdy) begin void'(q.pop_front()); delivered++; end
      if (occ < 2) begin q.push_back(nxt); nxt = nxt + 1'b1; end
      @(negedge clk);
    end
    in_fwd_v = 1'b0; out_fwd_rdy = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rnd_drain_idle: got %b, expected 1", idle); end
    tests++; if (delivered < 50) begin fails++; $display("FAIL rnd_delivered: got %0d, expected at least 50", delivered); end
  endtask

  task automatic test_async_reset();
    out_fwd_rdy = 1'b0;
    in_fwd_v = 1'b1; in_fwd_data = FW'(32'hAAAA);
    @(negedge clk);
    in_fwd_data = FW'(32'hBBBB);
    @(negedge clk);
    in_fwd_v = 1'b0;
    tests++; if (ino_fwd_rdy !== 1'b0) begin fails++; $display("FAIL areset_full_ready: got %b, expected 0", ino_fwd_rdy); end
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("areset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++; if (outo_fwd_v !== 1'b0) begin fails++; $display("FAIL areset_stale: got v=%b, expected 0", outo_fwd_v); end
    out_fwd_rdy = 1'b1;
    in_fwd_v = 1'b1; in_fwd_data = FW'(32'hCCCC);
    @(negedge clk);
    in_fwd_v = 1'b0;
    tests++; if (outo_fwd_v !== 1'b1 || outo_fwd_data !== FW'(32'hCCCC))
      begin fails++; $display("FAIL areset_first_word: got v=%b data=%h, expected v=1 data=%h", outo_fwd_v, outo_fwd_data, FW'(32'hCCCC)); end
    @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL areset_final_idle: got %b, expected 1", idle); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_throughput();
    test_random_ready();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/bsg_manycore_link_sif_edge_buffer.md
# bsg_manycore_link_sif_edge_buffer

Registered elastic buffer for one manycore link_sif at the edge of a compute tile array. It sits between one edge link of the array (a horizontal E/W port or a vertical N/S port) and the neighbouring block: a vcache row, an IO router, or another subarray. It places a 2-entry valid/ready FIFO on each of the four channels so the long edge wire is fully retimed. It does this without losing throughput.

## Interface
Parameters:
- addr_width_p, none: manycore EPA width (word address).
- data_width_p, none: manycore data width.
- x_cord_width_p, none: global X coordinate width.
- y_cord_width_p, none: global Y coordinate width.
- link_sif_width_lp (localparam): width of the link_sif struct for the four parameters above.

Ports:
- clk_i, input, 1: single clock.
- reset_n_i, input, 1: reset, asynchronous and active-low.
- inner_link_sif_i, input, link_sif_width_lp: from the array edge.
- inner_link_sif_o, output, link_sif_width_lp: to the array edge.
- outer_link_sif_i, input, link_sif_width_lp: from the neighbour.
- outer_link_sif_o, output, link_sif_width_lp: to the neighbour.
- idle_o, output, 1: all four FIFOs are empty.

Both link_sif ports are unpacked with the codebase link_sif struct. Each struct has a fwd field and a rev field, and each of those carries v, data and ready_and_rev.

## Operation
- There are four independent channels. Each channel is one instance of the same 2-entry FIFO.
  - F_OUT: inner_i.fwd.{v,data} -> outer_o.fwd. Ready flows back as outer_i.fwd.ready_and_rev -> inner_o.fwd.ready_and_rev.
  - F_IN: outer_i.fwd -> inner_o.fwd. Ready: inner_i.fwd.ready_and_rev -> outer_o.fwd.ready_and_rev.
  - R_OUT: inner_i.rev -> outer_o.rev. Ready: outer_i.rev.ready_and_rev -> inner_o.rev.ready_and_rev.
  - R_IN: outer_i.rev -> inner_o.rev. Ready: inner_i.rev.ready_and_rev -> outer_o.rev.ready_and_rev.
- Each FIFO has three states: EMPTY, ONE and FULL.
  - Enqueue when upstream v=1 and the FIFO's ready output=1.
  - Dequeue when the FIFO's v output=1 and downstream ready=1.
- State transitions:
  - EMPTY: enq -> ONE.
  - ONE: enq without deq -> FULL. Deq without enq -> EMPTY. Enq and deq together -> ONE, with the head replaced by the new word.
  - FULL: deq -> ONE. An enqueue cannot occur, because ready=0.
- Output v=1 in ONE or FULL. The output data is always the head entry, in strict FIFO order.
- The ready output is 1 exactly when the state is not FULL. It is driven from a register and has no combinational path from downstream ready.
- Storage: two entries of packet width with one read pointer and one write pointer. Each pointer is 1 bit and wraps 1 -> 0.
- Data values are never inspected or modified. Field widths pass through unchanged.
- idle_o = 1 when all four FIFOs are EMPTY. It is used by reset and drain sequencing.

## Timing
- Latency: a word enqueued at edge N is presented on the output v/data after edge N, so one cycle minimum.
- Throughput: one word per cycle per channel sustained, with all channels concurrent.
- A downstream stall of k cycles is absorbed by two entries. Upstream ready drops the cycle after the second entry fills.
- Ready recovers the cycle after the first dequeue from FULL.
- Asserting reset_n_i=0 forces, immediately and with no clock needed:
  - all FIFOs to EMPTY;
  - every output v to 0;
  - every output ready_and_rev to 0;
  - idle_o to 1.
- After reset deassertion (synchronized externally), the first rising edge still sees ready=0. Every ready output goes to 1 after that first edge.
- Reset mid-operation discards buffered words. No partial word is ever emitted.
- Storage data registers need no reset. While v=0 the output data is don't-care.

## Test plan
- Single packet: after reset, drive inner_i.fwd v=1 with data=0x1234_5678 at cycle 2 only, and hold the downstream ready at 1 -> outer_o.fwd v=1 with 0x1234_5678 at cycle 3 only, and idle_o=0 at cycle 3 only.
- Back-pressure: stream words 1,2,3,4 on R_IN with inner_i.rev.ready_and_rev=0 -> two words are accepted. outer_o.rev.ready_and_rev=0 from the cycle after the second accept. Releasing ready delivers 1,2,3,4 in order with no duplicate or drop.
- Full throughput: 100 consecutive words on all four channels simultaneously, with ready always 1 -> 100 words out per channel, one per cycle, in order, offset by one cycle.
- Enqueue and dequeue together in ONE: a random ready pattern at 50% with continuous valid -> no loss. The occupancy model always stays in 0..2 and matches the FIFO state every cycle.
- Asynchronous reset mid-stream: assert reset_n_i=0 between clock edges while F_OUT is FULL -> outer_o.fwd v and all ready outputs go to 0 before the next edge and idle_o=1. After release, the first word accepted is the first word out.
